// File: rtl/ysyx_24110006_pkg.sv
// ysyx_24110006_pkg: shared fetch-unit state encoding and constants
package ysyx_24110006_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_24110006_ifu.sv
// ysyx_24110006_ifu: multicycle instruction fetch with redirect and fault reporting
module ysyx_24110006_ifu
  import ysyx_24110006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_resp_valid,
  output logic        o_mem_resp_ready,
  input  logic [31:0] i_mem_resp_data,
  input  logic        i_mem_resp_err,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_fault,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc
);
  ifu_state_e state, state_n;
  logic [31:0] pc, pc_n, inst_n;
  logic        fault_n, drop, drop_n;
  logic        misaligned, discard;
  assign misaligned       = pc[1:0] != 2'b00;
  assign discard          = drop || i_redirect_valid;
  assign o_mem_req_valid  = state == REQ && !misaligned;
  assign o_mem_addr       = pc;
  assign o_mem_resp_ready = state == WAIT;
  assign o_inst_valid     = state == HOLD;
  assign o_pc             = pc;
  // next-state and next-data selection; a redirect always wins the PC mux
  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = o_inst;
    fault_n = o_fault;
    drop_n  = drop;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (misaligned && !i_redirect_valid) begin
          state_n = HOLD;
          inst_n  = NOP_INST;
          fault_n = 1'b1;
        end else if (!misaligned && i_mem_req_ready) begin
          state_n = WAIT;
          drop_n  = i_redirect_valid;
        end
      end
      WAIT: begin
        if (i_mem_resp_valid) begin
          state_n = discard ? REQ : HOLD;
          drop_n  = 1'b0;
          inst_n  = discard ? o_inst : i_mem_resp_data;
          fault_n = discard ? o_fault : i_mem_resp_err;
        end else if (i_redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (i_redirect_valid || i_inst_ready) begin
          state_n = REQ;
          pc_n    = pc + 32'd4;
        end
      end
      default: state_n = IDLE;
    endcase
    if (i_redirect_valid) pc_n = i_redirect_pc;
  end
  // fetch state and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      o_inst  <= 32'h0;
      o_fault <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      o_inst  <= inst_n;
      o_fault <= fault_n;
      drop    <= drop_n;
    end
  end
endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// tb_ysyx_24110006_ifu: directed self-checking bench for the fetch unit
module tb_ysyx_24110006_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_resp_valid = 1'b0, mem_resp_ready;
  logic [31:0] mem_resp_data = 32'h0;
  logic        mem_resp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, pc;
  logic        fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24110006_ifu dut (
    .i_clock(clk),
    .i_reset(rst),
    .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_req_ready),
    .o_mem_addr(mem_addr),
    .i_mem_resp_valid(mem_resp_valid),
    .o_mem_resp_ready(mem_resp_ready),
    .i_mem_resp_data(mem_resp_data),
    .i_mem_resp_err(mem_resp_err),
    .o_inst_valid(inst_valid),
    .i_inst_ready(inst_ready),
    .o_inst(inst),
    .o_pc(pc),
    .o_fault(fault),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_resp_ready", {31'h0, mem_resp_ready}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_pc", pc, 32'h8000_0000);
    // zero-wait memory
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0000_0093;
    inst_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("c1_idle_req_valid", {31'h0, mem_req_valid}, 32'h0);
    tick();
    chk("c2_req_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("c2_addr", mem_addr, 32'h8000_0000);
    tick();
    chk("c3_resp_ready", {31'h0, mem_resp_ready}, 32'h1);
    chk("c3_inst_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("c4_inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("c4_inst", inst, 32'h0000_0093);
    chk("c4_pc", pc, 32'h8000_0000);
    chk("c4_fault", {31'h0, fault}, 32'h0);
    tick();
    chk("c5_req_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("c5_addr", mem_addr, 32'h8000_0004);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    inst_ready = 1'b0;
    // request stall then delayed response
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("stall_addr", mem_addr, 32'h8000_0004);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("delay_resp_ready", {31'h0, mem_resp_ready}, 32'h1);
      chk("delay_inst_valid", {31'h0, inst_valid}, 32'h0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0010_0113;
    tick();
    mem_resp_valid = 1'b0;
    chk("delay_inst_valid_hi", {31'h0, inst_valid}, 32'h1);
    chk("delay_inst", inst, 32'h0010_0113);
    chk("delay_pc", pc, 32'h8000_0004);
    // decode back-pressure
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_inst_valid", {31'h0, inst_valid}, 32'h1);
      chk("bp_inst", inst, 32'h0010_0113);
      chk("bp_pc", pc, 32'h8000_0004);
      chk("bp_fault", {31'h0, fault}, 32'h0);
      chk("bp_req_valid", {31'h0, mem_req_valid}, 32'h0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp_next_addr", mem_addr, 32'h8000_0008);
    chk("bp_next_req", {31'h0, mem_req_valid}, 32'h1);
    // redirect while a response is in flight
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("rw_resp_ready", {31'h0, mem_resp_ready}, 32'h1);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    chk("rw_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rw_req_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("rw_addr", mem_addr, 32'h8000_0100);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0020_0193;
    tick();
    mem_resp_valid = 1'b0;
    chk("rw_new_inst", inst, 32'h0020_0193);
    chk("rw_new_pc", pc, 32'h8000_0100);
    // redirect beats accept in HOLD
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rh_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rh_req_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("rh_addr", mem_addr, 32'h8000_0200);
    // misaligned redirect from REQ
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("mis_addr", mem_addr, 32'h8000_0102);
    tick();
    chk("mis_inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_inst", inst, 32'h0000_0013);
    chk("mis_pc", pc, 32'h8000_0102);
    chk("mis_no_req", {31'h0, mem_req_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    chk("mis_exit_addr", mem_addr, 32'h8000_0300);
    // bus error response
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_err = 1'b1;
    mem_resp_data = 32'h0;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_err = 1'b0;
    chk("err_inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("err_fault", {31'h0, fault}, 32'h1);
    chk("err_pc", pc, 32'h8000_0300);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("err_next_addr", mem_addr, 32'h8000_0304);
    // PC wraps past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0030_0213;
    tick();
    mem_resp_valid = 1'b0;
    chk("wrap_fault_clr", {31'h0, fault}, 32'h0);
    chk("wrap_inst", inst, 32'h0030_0213);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_next_addr", mem_addr, 32'h0000_0000);
    // reset in the middle of a transaction
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("mid_wait", {31'h0, mem_resp_ready}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_ready", {31'h0, mem_resp_ready}, 32'h0);
    chk("mid_rst_pc", mem_addr, 32'h8000_0000);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h1234_5678;
    tick();
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_24110006_ifu.md
# ysyx_24110006_ifu

Instruction fetch unit for the multicycle NPC core. It holds the PC and issues one 32-bit read per instruction on the instruction-memory port. It presents the fetched word, its PC and a fault flag to the decode stage over a valid/ready handshake. Control-flow changes from execute/writeback arrive on a redirect port, which overrides sequential PC+4.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- i_clock  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- o_mem_req_valid  out  1  read request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_addr  out  32  request address (always the current PC)
- i_mem_resp_valid  in  1  read data valid
- o_mem_resp_ready  out  1  IFU accepts response (high only in WAIT)
- i_mem_resp_data  in  32  read data
- i_mem_resp_err  in  1  bus error on this response
- o_inst_valid  out  1  instruction available to decode
- i_inst_ready  in  1  decode consumes instruction
- o_inst  out  32  instruction word
- o_pc  out  32  PC of o_inst
- o_fault  out  1  fetch fault: bus error or misaligned PC
- i_redirect_valid  in  1  load new PC
- i_redirect_pc  in  32  redirect target

## Operation
- States: IDLE, REQ, WAIT, HOLD. The state register is reset to IDLE.
- Reset values:
  - pc = RESET_PC.
  - o_inst = 0, o_fault = 0, drop = 0.
  - All valid/ready outputs are 0.
- IDLE: unconditionally moves to REQ on the next edge.
- REQ:
  - o_mem_req_valid = 1, o_mem_addr = pc.
  - On i_mem_req_ready, go to WAIT.
- WAIT:
  - o_mem_resp_ready = 1.
  - On i_mem_resp_valid with drop = 0: register o_inst = data and o_fault = err, then go to HOLD.
  - On i_mem_resp_valid with drop = 1: discard the response, clear drop, go to REQ.
- HOLD:
  - o_inst_valid = 1; o_inst, o_pc and o_fault are held stable.
  - On i_inst_ready: pc <= pc + 4 (mod 2^32, wraps silently), go to REQ.
- Redirect (i_redirect_valid), by state:
  - IDLE or REQ without a handshake: pc <= i_redirect_pc, stay or enter REQ. This is the only case where o_mem_addr may change while valid is high; the memory side tolerates it.
  - REQ with i_mem_req_ready in the same cycle: the request is already issued. Set drop = 1, pc <= target, go to WAIT.
  - WAIT: set drop = 1 (unless the response arrives the same cycle; then discard it and go directly to REQ), pc <= target.
  - HOLD: redirect beats i_inst_ready. The instruction is not consumed; pc <= target, go to REQ.
- Misaligned PC (pc[1:0] != 0) on entering REQ:
  - No memory request is issued.
  - Next state is HOLD with o_inst = 32'h0000_0013 (nop) and o_fault = 1.
  - Redirects take effect as above.
- Reset assertion mid-transaction returns to IDLE immediately. A response arriving after reset is ignored: o_mem_resp_ready is 0 outside WAIT.

## Timing
- All outputs are registered, or decoded only from the state register; no input-to-output combinational path.
- Zero-wait memory (ready and resp_valid both high on the first opportunity), one instruction every 3 cycles:
  - T: REQ handshake.
  - T+1: WAIT plus response.
  - T+2: HOLD with o_inst_valid and accept.
  - T+3: REQ for PC+4.
- First o_inst_valid after reset deassertion: cycle 4 with zero-wait memory.
- Redirect-to-request latency: 1 cycle from HOLD or WAIT. A dropped response adds the memory response latency.
- At most one outstanding memory request.

## Structure
- Shared package ysyx_24110006_pkg holds:
  - state encoding (IDLE=0, REQ=1, WAIT=2, HOLD=3);
  - NOP_INST = 32'h0000_0013;
  - the default RESET_PC.
- Single flat module with no sub-module. The PC/next-PC mux is internal and small.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0093 at 8000_0000:
  - o_inst_valid rises at cycle 4 with o_pc = 8000_0000.
  - The next request address is 8000_0004.
- Memory stalls i_mem_req_ready for 5 cycles and delays the response 3 cycles: o_mem_addr and o_mem_req_valid are stable throughout, and exactly one instruction is delivered.
- Decode holds i_inst_ready low for 10 cycles: o_inst, o_pc and o_fault are unchanged, and no new request is issued.
- Redirect to 8000_0100 during WAIT:
  - The in-flight response (32'hDEAD_BEEF) is never presented.
  - The next request is 8000_0100.
- Redirect and i_inst_ready in the same HOLD cycle: the instruction is not counted as consumed, and the next request is at the redirect target.
- Faults:
  - Redirect to 8000_0102 produces o_fault = 1 and o_inst = 32'h0000_0013 with no memory request.
  - i_mem_resp_err = 1 produces o_fault = 1 with o_pc equal to the request address.
